// File: rtl/alu_defs.sv
// Shared execute-stage definitions: multiplier FSM states and the widened
// 3-bit ALU result-type codes that select the multiplier product halves.
package alu_defs;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam int RES_SEL_W = 3;

    parameter logic [RES_SEL_W-1:0] RES_MUL_LO = 3'd4;
    parameter logic [RES_SEL_W-1:0] RES_MUL_HI = 3'd5;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative radix-2 shift-add multiplier with start/busy/done handshake.
// Build option ALU_MUL_SIGNED_EN adds the is_signed port (sign-magnitude signed multiply).
module alu_mul_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_MUL_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    mul_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     res_lo_q, res_lo_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;

    logic [WIDTH-1:0]     a_cap_s, b_cap_s;
    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   final_s;
    logic                 accept_s;

`ifdef ALU_MUL_SIGNED_EN
    logic                 sign_q, sign_d;
    logic                 sign_cap_s;

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // Operands enter the shift-add core as magnitudes; the sign is re-applied at the end.
    always_comb begin
        a_cap_s    = op_a;
        b_cap_s    = op_b;
        sign_cap_s = 1'b0;
        if (is_signed) begin
            a_cap_s    = mag_w(op_a);
            b_cap_s    = mag_w(op_b);
            sign_cap_s = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end else begin
            sign_cap_s = 1'b0;
        end
    end
`else
    assign a_cap_s = op_a;
    assign b_cap_s = op_b;
`endif

    // Datapath step: the WIDTH+1-bit sum keeps the carry that the right shift pulls into the accumulator.
    always_comb begin
        addend_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum_s    = {1'b0, acc_q} + {1'b0, addend_s};
        prod_s   = {sum_s, mplier_q[WIDTH-1:1]};
`ifdef ALU_MUL_SIGNED_EN
        if (sign_q) begin
            final_s = neg_2w(prod_s);
        end else begin
            final_s = prod_s;
        end
`else
        final_s = prod_s;
`endif
    end

    assign accept_s = start && ((state_q == MUL_IDLE) || (state_q == MUL_DONE));

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
`ifdef ALU_MUL_SIGNED_EN
        sign_d   = sign_q;
`endif
        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (accept_s) begin
                    state_d  = MUL_CALC;
                    cnt_d    = CNT_LOAD;
                    mcand_d  = a_cap_s;
                    mplier_d = b_cap_s;
                    acc_d    = {WIDTH{1'b0}};
`ifdef ALU_MUL_SIGNED_EN
                    sign_d   = sign_cap_s;
`endif
                end else begin
                    state_d  = MUL_IDLE;
                end
            end
            MUL_CALC: begin
                acc_d    = prod_s[2*WIDTH-1:WIDTH];
                mplier_d = prod_s[WIDTH-1:0];
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = MUL_DONE;
                    res_lo_d = final_s[WIDTH-1:0];
                    res_hi_d = final_s[2*WIDTH-1:WIDTH];
                end else begin
                    state_d  = MUL_CALC;
                end
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            res_lo_q <= {WIDTH{1'b0}};
            res_hi_q <= {WIDTH{1'b0}};
`ifdef ALU_MUL_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
`ifdef ALU_MUL_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    assign busy      = (state_q == MUL_CALC);
    assign done      = (state_q == MUL_DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq (WIDTH=32); signed vectors run
// only when ALU_MUL_SIGNED_EN is defined.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
`ifdef ALU_MUL_SIGNED_EN
    logic        is_signed;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_mul_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef ALU_MUL_SIGNED_EN
        .is_signed (is_signed),
`endif
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n cycles in CALC: busy high, no done, previous product held.
    task automatic calc_cycles(input int n, input string tag,
                               input logic [31:0] hold_lo, input logic [31:0] hold_hi);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_nodone"}, 64'(done), 64'd0);
            check({tag, "_hold"}, {result_hi, result_lo}, {hold_hi, hold_lo});
            tick();
        end
    endtask

    // Full operation from IDLE: accept, 32 busy cycles, one done cycle, then idle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input logic [63:0] prev);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        calc_cycles(32, tag, prev[31:0], prev[63:32]);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        check({tag, "_product"}, {result_hi, result_lo}, exp);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_held"}, {result_hi, result_lo}, exp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = 32'd0;
        op_b  = 32'd0;
`ifdef ALU_MUL_SIGNED_EN
        is_signed = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", {result_hi, result_lo}, 64'd0);

        run_op("basic_7x6", 32'd7, 32'd6, 64'd42, 64'd0);
        run_op("full_carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 64'd42);
        run_op("zero_a", 32'd0, 32'h1234_5678, 64'd0, 64'hFFFF_FFFE_0000_0001);
        run_op("pow2_mix", 32'h8000_0000, 32'd3, 64'h0000_0001_8000_0000, 64'd0);

        // start during CALC is ignored, then a back-to-back start in the done cycle
        op_a  = 32'd3;
        op_b  = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        calc_cycles(9, "ign_a", 32'h8000_0000, 32'd1);
        op_a  = 32'd9;
        op_b  = 32'd9;
        start = 1'b1;
        check("ign_busy_at_10", 64'(busy), 64'd1);
        tick();
        start = 1'b0;
        calc_cycles(22, "ign_b", 32'h8000_0000, 32'd1);
        check("ign_done", 64'(done), 64'd1);
        check("ign_product", {result_hi, result_lo}, 64'd15);
        op_a  = 32'd9;
        op_b  = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_no_idle", 64'(busy), 64'd1);
        calc_cycles(32, "b2b", 32'd15, 32'd0);
        check("b2b_done", 64'(done), 64'd1);
        check("b2b_product", {result_hi, result_lo}, 64'd81);
        tick();
        check("b2b_done_pulse", 64'(done), 64'd0);

        // reset in the middle of 100x100
        op_a  = 32'd100;
        op_b  = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        calc_cycles(11, "abort", 32'd81, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", {result_hi, result_lo}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort_no_done", 64'(done), 64'd0);
            check("abort_no_busy", 64'(busy), 64'd0);
        end

        run_op("after_abort", 32'd100, 32'd100, 64'd10000, 64'd0);

`ifdef ALU_MUL_SIGNED_EN
        is_signed = 1'b1;
        run_op("signed_m3x4", 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4, 64'd10000);
        run_op("signed_m3xm3", 32'hFFFF_FFFD, 32'hFFFF_FFFD, 64'd9, 64'hFFFF_FFFF_FFFF_FFF4);
        is_signed = 1'b0;
        run_op("unsigned_same_bits", 32'hFFFF_FFFD, 32'd4, 64'h0000_0003_FFFF_FFF4, 64'd9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative radix-2 shift-add multiplier. It sits beside the single-cycle ALU in the execute stage.
- Its product feeds the ALU result mux as an additional result type, RES_MUL.
- Uses a start/busy/done handshake; the control unit stalls PC update while busy=1.
- Produces a 2*WIDTH-bit product, exposed as low and high halves.

Parameters:
- WIDTH, 32: operand width in bits; legal values are 8, 16 and 32.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new multiply; sampled only in IDLE or DONE
- op_a  input  WIDTH  multiplicand; captured on the accepted start
- op_b  input  WIDTH  multiplier; captured on the accepted start
- busy  output  1  high while iterating
- done  output  1  single-cycle pulse when the product is valid
- result_lo  output  WIDTH  product bits [WIDTH-1:0]
- result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, counter=0, internal registers=0.
- States:
  - IDLE: start=1 → capture op_a/op_b, clear the accumulator, load counter=WIDTH, go to CALC.
  - CALC: each cycle, if multiplier LSB=1 add the multiplicand into the upper accumulator (WIDTH+1-bit sum keeps the carry). Then shift {carry, acc, mplier} right by 1 and decrement the counter. When counter reaches 1, go to DONE on the same edge as the final iteration.
  - DONE: done=1 for exactly one cycle. start=1 here → accept the new operation and go to CALC (back-to-back). Otherwise go to IDLE.
- Timing:
  - start accepted in cycle t → busy=1 in cycles t+1 … t+WIDTH.
  - done=1 in cycle t+WIDTH+1 only.
  - result_lo/result_hi are valid from t+WIDTH+1 and held until the next accepted start completes.
- Outputs during a new operation: result_lo/result_hi are not cleared on an accepted start. They update only on the transition into DONE.
- start in CALC is ignored; it is neither queued nor an error.
- op_a/op_b changing after capture has no effect.
- busy is combinational from state (state==CALC), glitch-free by registered state. done is likewise (state==DONE).
- Operand boundaries:
  - 0×anything → 0.
  - (2^WIDTH-1)×(2^WIDTH-1) → hi=2^WIDTH-2, lo=1. No overflow is lost; the carry bit is mandatory.
- rst=1 in any state, including mid-CALC → next cycle IDLE with all reset values. A pending product is discarded.
- Unsigned arithmetic unless the optional feature is compiled in.

Optional Feature:
- Macro: ALU_MUL_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), captured with the operands.
  - When is_signed=1: operands are converted to magnitudes on capture and the sign (op_a[MSB] ^ op_b[MSB]) is stored. On the transition into DONE the 2*WIDTH-bit product is two's-complement negated if the stored sign=1.
  - Latency is unchanged.
- Not defined:
  - No is_signed port; purely unsigned.

Decomposition:
- Package alu_defs gains:
  - typedef enum logic [1:0] mul_state_t {MUL_IDLE, MUL_CALC, MUL_DONE}
  - parameter RES_MUL_LO / RES_MUL_HI as result-select codes for the ALU result mux, using a widened 3-bit result-type field
- No sub-module required. The datapath (accumulator plus adder) and the FSM fit in one module of about 150–250 lines.

Test Plan:
- Basic product: rst for 2 cycles, then start with op_a=7, op_b=6 (WIDTH=32) → busy high cycles 1–32, done pulse at cycle 33, result_lo=42, result_hi=0.
- Full-carry case: op_a=op_b=32'hFFFF_FFFF → result_hi=32'hFFFF_FFFE, result_lo=32'h0000_0001.
- Start ignored while busy: start=1 with 3×5, then start=1 again with 9×9 at cycle 10 → second start ignored, result=15. Next, assert start in the done cycle with 9×9 → busy resumes next cycle, result=81 after 33 more cycles, and no IDLE cycle between the two operations.
- Reset mid-operation: rst at cycle 12 of 100×100 → busy=0, done=0, results=0 the following cycle; no done pulse ever appears for the aborted operation.
- Zero operand: op_a=0, op_b=32'h1234_5678 → 0/0, with latency still WIDTH+1 cycles.
- Signed (ALU_MUL_SIGNED_EN, is_signed=1): op_a=-3, op_b=4 → {hi,lo}=64'hFFFF_FFFF_FFFF_FFF4. With is_signed=0 and the same bits → unsigned product.
